mem_sequencer: RTL

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_sequencer.sv
// Sequencer that shares one memory bus between instruction fetch and data access.
// It walks fetch, decode, optional data access and commit, and has a sticky bus-timeout trap.
module mem_sequencer #(
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [31:0] NopInstr      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] instr,
  output logic [31:0] d_rdata,
  output logic        core_en,
  output logic        bus_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    DATA   = 3'd3,
    COMMIT = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam logic [7:0] TimeoutLimit = 8'(TimeoutCycles);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       xfer_done;
  logic       timeout;

  // Handshake: a transfer completes on a rising edge where mem_valid and
  // mem_ready are both 1. mem_valid/addr/wdata/wstrb are decoded from the state
  // and the core's inputs, which the core holds for the whole instruction, so
  // they stay stable until completion; mem_ready is ignored while mem_valid=0.
  always_comb begin
    mem_valid  = (state == FETCH) || (state == DATA);
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_wstrb  = 4'd0;
    core_en    = 1'b0;
    state_next = state;
    xfer_done  = mem_valid && mem_ready;
    timeout    = mem_valid && !mem_ready && (wait_cnt == TimeoutLimit);
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        mem_addr = pc;
        if (xfer_done)    state_next = DECODE;
        else if (timeout) state_next = ERROR;
      end
      DECODE: begin
        if (d_req) begin
          state_next = DATA;
        end else begin
          core_en    = 1'b1;
          state_next = FETCH;
        end
      end
      DATA: begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
        if (xfer_done)    state_next = COMMIT;
        else if (timeout) state_next = ERROR;
      end
      COMMIT: begin
        core_en    = 1'b1;
        state_next = FETCH;
      end
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      instr    <= NopInstr;
      d_rdata  <= 32'd0;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_next;
      // Counter is zero whenever no transfer is outstanding, so every new transfer starts fresh.
      if (!mem_valid || xfer_done) wait_cnt <= 8'd0;
      else if (!timeout)           wait_cnt <= wait_cnt + 8'd1;
      if (state == FETCH && xfer_done) instr <= mem_rdata;
      if (state == DATA && xfer_done && d_wstrb == 4'd0) d_rdata <= mem_rdata;
      if (timeout) bus_err <= 1'b1;
    end
  end

  assign dbg_state = state;

endmodule
